health_manager: RTL
===================

// Module: health_manager
// PURPOSE
//  Receiving end of the damage interface. Consumes per-player damage streams (player_dmgN, hitN),
//  keeps authoritative HP for both players and a per-frame drained HP for the health-bar sprites.
//  Runs the round FSM (IDLE/FIGHT/KO/OVER) and reports KO, winner and a hurt-flash flag.
//  Sits between the damage generator and the VGA/HUD drawing logic.
// PARAMETERS
//  MAX_HP      100  HP loaded into both players at round start (must fit 10 bits)
//  DRAIN_STEP  1    disp_hp step toward hp per frame_tick
//  KO_FRAMES   120  frame_ticks spent in KO before OVER
// PORTS
//  clk           in   1   system clock
//  reset         in   1   asynchronous, active-high reset
//  frame_tick    in   1   one-clk pulse per video frame
//  round_start   in   1   one-clk pulse; starts a round from IDLE or OVER
//  player_dmg1   in   10  damage stream for player 1 (from damage generator)
//  player_dmg2   in   10  damage stream for player 2
//  hit1, hit2    in   4   hit-stun countdown of each player (nonzero = stunned)
//  hp1, hp2      out  10  authoritative HP
//  disp_hp1/2    out  10  drained HP for health bars
//  hurt1, hurt2  out  1   high while hitN != 0 and state == FIGHT (sprite flash)
//  ko1, ko2      out  1   player reached 0 HP this round (sticky until next round_start)
//  winner        out  2   00 none, 01 P1, 10 P2, 11 draw; valid in OVER
//  state_o       out  2   current FSM state encoding
// BEHAVIOUR
//  Reset: state=IDLE; hp/disp_hp=MAX_HP; ko=0; winner=00; hurt=0; dmg_prev regs=0; ko_cnt=0.
//  Damage decode (per player, every clk): dmg_prev <= player_dmgN.
//   if player_dmgN > dmg_prev: delta = player_dmgN - dmg_prev; else delta = 0.
//   So melee 0->10 costs 10 once; 10->0 costs 0; ball n->n+1 costs 1 per step.
//   Decode runs in all states; the register tracks continuously.
//  HP update: only in FIGHT; hp <= (delta >= hp) ? 0 : hp - delta. Same clk as the input change.
//   Both players update independently in the same cycle. No underflow, no wrap.
//  Drain: on frame_tick, if disp_hp > hp then disp_hp <= max(hp, disp_hp - DRAIN_STEP).
//   If disp_hp < hp (reload), then disp_hp <= hp immediately.
//  FSM:
//   IDLE -> FIGHT on round_start: hp=disp_hp=MAX_HP, ko=0, winner=00.
//   FIGHT -> KO when either hp==0 (registered value). ko1/ko2 set for each hp==0 that cycle.
//    A same-cycle double KO gives winner=11; otherwise the non-KO player wins.
//    winner is latched on entry to KO.
//   KO: damage ignored; ko_cnt counts frame_ticks; -> OVER when ko_cnt==KO_FRAMES-1 on a tick.
//   OVER: outputs held. round_start -> FIGHT with reload as in IDLE.
//   round_start is ignored in FIGHT/KO.
//  Reset mid-round returns to IDLE with reset values; no partial damage is applied.
//  Latency: player_dmg change -> hp 1 clk; hp==0 -> ko/state KO 1 further clk.
// STRUCTURE
//  Shared package game_pkg: typedef enum logic[1:0] {IDLE,FIGHT,KO,OVER} round_state_t;
//   WINNER_* localparams; MAX_HP default.
//  Sub-module hp_channel (instantiated twice): dmg_prev register, delta decode, saturating hp,
//   disp_hp drain, hurt. Ports are en_damage and reload, driven by the FSM.
//  Top holds FSM, ko_cnt, winner logic.
// TESTING
//  1 round_start; P1 dmg 0->10->0 -> hp1 100->90 after 1 clk, no further loss; hurt1 follows hit1.
//  2 P2 dmg ramps 0..5 one per clk -> hp2 = 95.
//    Then 30 frame_ticks -> disp_hp2 100->95 and stops.
//  3 hp1=5, dmg1 0->10 -> hp1=0 (saturate), next clk state=KO, ko1=1, winner=10.
//  4 hp1=hp2=10; both dmg 0->10 same clk -> ko1=ko2=1, winner=11.
//  5 In KO, dmg pulses -> hp unchanged; after KO_FRAMES ticks -> OVER.
//    round_start -> FIGHT, hp=disp_hp=100, ko=0.
//  6 Assert reset mid-FIGHT with hp1=40 -> immediate IDLE, hp1=100, all flags 0.
//    round_start in FIGHT is ignored.

Source files
------------

// File: rtl/game_pkg.sv
// Shared round-state encoding, winner codes and HP defaults for the
// fighting-game health and round logic.
package game_pkg;

    localparam int HP_W = 10;
    localparam int MAX_HP_DEFAULT = 100;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FIGHT = 2'd1,
        KO    = 2'd2,
        OVER  = 2'd3
    } round_state_t;

    localparam logic [1:0] WINNER_NONE = 2'b00;
    localparam logic [1:0] WINNER_P1   = 2'b01;
    localparam logic [1:0] WINNER_P2   = 2'b10;
    localparam logic [1:0] WINNER_DRAW = 2'b11;

endpackage

// File: rtl/hp_channel.sv
// One player's HP path: rising-edge damage decode, saturating HP,
// per-frame health-bar drain and hurt flash.
module hp_channel
    import game_pkg::*;
#(
    parameter int MAX_HP     = MAX_HP_DEFAULT,
    parameter int DRAIN_STEP = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            frame_tick,
    input  logic            en_damage,
    input  logic            reload,
    input  logic [HP_W-1:0] dmg,
    input  logic [3:0]      hit,
    output logic [HP_W-1:0] hp,
    output logic [HP_W-1:0] disp_hp,
    output logic            hurt
);

    localparam logic [HP_W-1:0] FULL = HP_W'(MAX_HP);
    localparam logic [HP_W-1:0] STEP = HP_W'(DRAIN_STEP);

    logic [HP_W-1:0] dmg_prev;
    logic [HP_W-1:0] delta;
    logic [HP_W-1:0] hp_next;
    logic [HP_W-1:0] disp_next;

    // Only increases of the stream cost HP; falling edges are free.
    always_comb begin
        delta = '0;
        if (dmg > dmg_prev) begin
            delta = dmg - dmg_prev;
        end
    end

    always_comb begin
        hp_next = hp;
        if (reload) begin
            hp_next = FULL;
        end else if (en_damage) begin
            hp_next = (delta >= hp) ? '0 : hp - delta;
        end
    end

    always_comb begin
        disp_next = disp_hp;
        if (reload) begin
            disp_next = FULL;
        end else if (disp_hp < hp) begin
            disp_next = hp;
        end else if (frame_tick && (disp_hp > hp)) begin
            disp_next = (disp_hp - hp > STEP) ? disp_hp - STEP : hp;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dmg_prev <= '0;
            hp       <= FULL;
            disp_hp  <= FULL;
        end else begin
            dmg_prev <= dmg;
            hp       <= hp_next;
            disp_hp  <= disp_next;
        end
    end

    assign hurt = en_damage && (hit != 4'd0);

endmodule

// File: rtl/health_manager.sv
// Round FSM, KO timer and winner latch around two HP channels;
// feeds the HUD health bars and sprite flash.
module health_manager
    import game_pkg::*;
#(
    parameter int MAX_HP     = MAX_HP_DEFAULT,
    parameter int DRAIN_STEP = 1,
    parameter int KO_FRAMES  = 120
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            frame_tick,
    input  logic            round_start,
    input  logic [HP_W-1:0] player_dmg1,
    input  logic [HP_W-1:0] player_dmg2,
    input  logic [3:0]      hit1,
    input  logic [3:0]      hit2,
    output logic [HP_W-1:0] hp1,
    output logic [HP_W-1:0] hp2,
    output logic [HP_W-1:0] disp_hp1,
    output logic [HP_W-1:0] disp_hp2,
    output logic            hurt1,
    output logic            hurt2,
    output logic            ko1,
    output logic            ko2,
    output logic [1:0]      winner,
    output logic [1:0]      state_o
);

    localparam int CNT_W = (KO_FRAMES > 1) ? $clog2(KO_FRAMES) : 1;

    round_state_t     state;
    round_state_t     state_next;
    logic             reload;
    logic             enter_ko;
    logic             fight;
    logic             ko_last;
    logic [CNT_W-1:0] ko_cnt;

    assign fight   = (state == FIGHT);
    assign ko_last = (ko_cnt == CNT_W'(KO_FRAMES - 1));
    assign state_o = state;

    hp_channel #(
        .MAX_HP     (MAX_HP),
        .DRAIN_STEP (DRAIN_STEP)
    ) u_ch1 (
        .clk        (clk),
        .reset      (reset),
        .frame_tick (frame_tick),
        .en_damage  (fight),
        .reload     (reload),
        .dmg        (player_dmg1),
        .hit        (hit1),
        .hp         (hp1),
        .disp_hp    (disp_hp1),
        .hurt       (hurt1)
    );

    hp_channel #(
        .MAX_HP     (MAX_HP),
        .DRAIN_STEP (DRAIN_STEP)
    ) u_ch2 (
        .clk        (clk),
        .reset      (reset),
        .frame_tick (frame_tick),
        .en_damage  (fight),
        .reload     (reload),
        .dmg        (player_dmg2),
        .hit        (hit2),
        .hp         (hp2),
        .disp_hp    (disp_hp2),
        .hurt       (hurt2)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        reload     = 1'b0;
        enter_ko   = 1'b0;
        unique case (state)
            IDLE, OVER: begin
                if (round_start) begin
                    state_next = FIGHT;
                    reload     = 1'b1;
                end
            end
            FIGHT: begin
                if ((hp1 == '0) || (hp2 == '0)) begin
                    state_next = KO;
                    enter_ko   = 1'b1;
                end
            end
            KO: begin
                if (frame_tick && ko_last) begin
                    state_next = OVER;
                end
            end
        endcase
    end

    // KO flags and winner are captured once, on the FIGHT->KO edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ko1    <= 1'b0;
            ko2    <= 1'b0;
            winner <= WINNER_NONE;
            ko_cnt <= '0;
        end else if (reload) begin
            ko1    <= 1'b0;
            ko2    <= 1'b0;
            winner <= WINNER_NONE;
            ko_cnt <= '0;
        end else if (enter_ko) begin
            ko1    <= (hp1 == '0);
            ko2    <= (hp2 == '0);
            ko_cnt <= '0;
            if ((hp1 == '0) && (hp2 == '0)) begin
                winner <= WINNER_DRAW;
            end else if (hp1 == '0) begin
                winner <= WINNER_P2;
            end else begin
                winner <= WINNER_P1;
            end
        end else if ((state == KO) && frame_tick) begin
            ko_cnt <= ko_last ? '0 : ko_cnt + 1'b1;
        end
    end

endmodule
